// File: rtl/cdc_fifo_burst.sv
// rtl/cdc_fifo_burst.sv - bursted Avalon block reader feeding a word FIFO for the CDC data port
module cdc_fifo_burst #(
  parameter int DW         = 16,
  parameter int AW         = 32,
  parameter int DEPTH_LOG2 = 11,
  parameter int BURST_LOG2 = 3,
  parameter int LEN_W      = 16
) (
  input  logic                  avm_clk,
  input  logic                  avm_reset_n,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  logic                  fifo_clr,
  input  logic [AW-1:0]         blk_addr,
  input  logic [LEN_W-1:0]      blk_size,
  input  logic                  rd_req,
  output logic [DW-1:0]         rd_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  busy,
  output logic                  ovf,
  output logic                  blk_dma_end,
  output logic [AW-1:0]         avm_addr,
  output logic                  avm_read,
  output logic [BURST_LOG2:0]   avm_burstcount,
  input  logic                  avm_wait,
  input  logic                  avm_rdvalid,
  input  logic [DW-1:0]         avm_rdata
);
  localparam int BSH = $clog2(DW / 8);
  localparam int PW  = DEPTH_LOG2 + 1;
  localparam int CW  = BURST_LOG2 + 1;
  localparam logic [PW-1:0]    DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LEN_W-1:0] MAX_BURST = LEN_W'(2 ** BURST_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_BEAT, S_DONE} state_t;

  state_t           state;
  logic [AW-1:0]    addr_q;
  logic [LEN_W-1:0] remaining;
  logic [CW-1:0]    outstanding;
  logic             abort_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [DW-1:0]    mem [0:(2**DEPTH_LOG2)-1];

  logic [CW-1:0]    len_c;
  logic [PW-1:0]    free_c;
  logic             issue_ok, abort_eff, push_req, pop;

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == DEPTH);
  assign busy       = (state != S_IDLE);

  always_comb begin
    len_c    = (remaining >= MAX_BURST) ? CW'(MAX_BURST) : CW'(remaining);
    free_c   = DEPTH - fifo_level;
    issue_ok = (free_c >= {{(PW-CW){1'b0}}, len_c});
    abort_eff = abort_q | ctrl_abort;
    push_req = (state == S_BEAT) && avm_rdvalid && !abort_eff;
    pop      = rd_req && !fifo_empty;
  end

  // Storage has no reset so it can map onto block RAM; pointers carry the state.
  always_ff @(posedge avm_clk) begin
    if (push_req && !fifo_full && !fifo_clr)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= avm_rdata;
  end

  always_ff @(posedge avm_clk or negedge avm_reset_n) begin
    if (!avm_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      ovf     <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_req && !fifo_full)
        wr_ptr <= wr_ptr + PW'(1);
      if (push_req && fifo_full)
        ovf <= 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
    end
  end

  always_ff @(posedge avm_clk or negedge avm_reset_n) begin
    if (!avm_reset_n) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      remaining      <= '0;
      outstanding    <= '0;
      abort_q        <= 1'b0;
      avm_read       <= 1'b0;
      avm_addr       <= '0;
      avm_burstcount <= '0;
      blk_dma_end    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          blk_dma_end <= 1'b0;
          abort_q     <= 1'b0;
          if (ctrl_start && !ctrl_abort)
            state <= S_LOAD;
        end
        S_LOAD: begin
          addr_q    <= blk_addr;
          remaining <= blk_size >> BSH;
          state     <= ((blk_size >> BSH) == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          // Once the request is on the bus it must complete; abort only applies before it.
          if (avm_read) begin
            if (!avm_wait) begin
              avm_read    <= 1'b0;
              outstanding <= avm_burstcount;
              remaining   <= remaining - LEN_W'(avm_burstcount);
              addr_q      <= addr_q + (AW'(avm_burstcount) << BSH);
              state       <= S_BEAT;
            end
          end else if (ctrl_abort) begin
            state <= S_IDLE;
          end else if (issue_ok) begin
            avm_read       <= 1'b1;
            avm_addr       <= addr_q;
            avm_burstcount <= len_c;
          end
        end
        S_BEAT: begin
          if (ctrl_abort)
            abort_q <= 1'b1;
          if (avm_rdvalid) begin
            outstanding <= outstanding - CW'(1);
            if (outstanding == CW'(1)) begin
              if (abort_eff) begin
                abort_q <= 1'b0;
                state   <= S_IDLE;
              end else begin
                state <= (remaining == '0) ? S_DONE : S_ISSUE;
              end
            end
          end
        end
        S_DONE: begin
          if (ctrl_abort) begin
            state <= S_IDLE;
          end else if (!ctrl_start) begin
            blk_dma_end <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdc_fifo_burst.sv
// tb/tb_cdc_fifo_burst.sv - scoreboard bench with Avalon slave model for cdc_fifo_burst
module tb_cdc_fifo_burst;
  localparam int DW = 16, AW = 32, DL = 5, BL = 3, LW = 16;
  localparam int DEPTH = 32, B = 2, MAXB = 8;

  logic avm_clk = 0, avm_reset_n = 1;
  logic ctrl_start = 0, ctrl_abort = 0, fifo_clr = 0;
  logic [AW-1:0] blk_addr = '0;
  logic [LW-1:0] blk_size = '0;
  logic rnd_req = 0, man_req = 0, rd_req;
  logic [DW-1:0] rd_data;
  logic [DL:0] fifo_level;
  logic fifo_empty, fifo_full, busy, ovf, blk_dma_end;
  logic [AW-1:0] avm_addr;
  logic avm_read;
  logic [BL:0] avm_burstcount;
  logic avm_wait = 0, avm_rdvalid = 0;
  logic [DW-1:0] avm_rdata = '0;

  assign rd_req = rnd_req | man_req;
  always #5 avm_clk = ~avm_clk;

  cdc_fifo_burst #(.DW(DW), .AW(AW), .DEPTH_LOG2(DL), .BURST_LOG2(BL), .LEN_W(LW)) dut (
    .avm_clk(avm_clk), .avm_reset_n(avm_reset_n), .ctrl_start(ctrl_start),
    .ctrl_abort(ctrl_abort), .fifo_clr(fifo_clr), .blk_addr(blk_addr), .blk_size(blk_size),
    .rd_req(rd_req), .rd_data(rd_data), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .busy(busy), .ovf(ovf), .blk_dma_end(blk_dma_end),
    .avm_addr(avm_addr), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_wait(avm_wait), .avm_rdvalid(avm_rdvalid), .avm_rdata(avm_rdata));

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dfun(input logic [AW-1:0] a);
    return a[15:0] ^ a[31:16] ^ 16'hC35A;
  endfunction

  typedef struct { logic [AW-1:0] addr; int len; } req_t;
  req_t req_q[$];
  logic [DW-1:0] exp_q[$];

  int beats_left = 0, wait_cnt = 0, stall_cfg = 0, model_lvl = 0;
  int st_cnt = 0, end_cnt = 0, req_cnt = 0, pop_pct = 0;
  bit gaps_en = 0, in_req = 0, pop_en = 0;
  bit store_r = 0, pop_r = 0, emp_r = 0, clr_r = 0;
  logic [AW-1:0] cur_addr = '0, first_addr = '0;
  logic [BL:0] first_bc = '0;
  logic [DW-1:0] last_exp = '0;

  // Slave model plus FIFO monitor, all on the falling edge.
  initial forever begin
    req_t r;
    @(negedge avm_clk);
    if (!avm_reset_n) begin
      beats_left = 0; in_req = 0; avm_rdvalid = 0; avm_wait = 0;
      model_lvl = 0; exp_q.delete(); req_q.delete(); last_exp = '0;
      store_r = 0; pop_r = 0; emp_r = 0; clr_r = 0;
    end else begin
      if (clr_r) begin
        model_lvl = 0;
        exp_q.delete();
      end else begin
        if (store_r) model_lvl++;
        if (pop_r) begin
          chk("exp_q_has_word", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) last_exp = exp_q.pop_front();
          model_lvl--;
        end
      end
      chk("fifo_level", fifo_level, model_lvl);
      chk("fifo_empty", fifo_empty, model_lvl == 0);
      chk("fifo_full", fifo_full, model_lvl == DEPTH);
      if (pop_r || emp_r) chk("rd_data", rd_data, last_exp);
      if (blk_dma_end) end_cnt++;

      avm_rdvalid = 0;
      if (beats_left > 0 && !(gaps_en && $urandom_range(0, 3) == 0)) begin
        avm_rdvalid = 1;
        avm_rdata = dfun(cur_addr);
        cur_addr += B;
        beats_left--;
      end
      avm_wait = 0;
      if (avm_read) begin
        if (!in_req) begin
          in_req = 1;
          wait_cnt = (stall_cfg < 0) ? $urandom_range(0, 3) : stall_cfg;
          first_addr = avm_addr;
          first_bc = avm_burstcount;
        end else begin
          chk("addr_stable", avm_addr, first_addr);
          chk("bc_stable", avm_burstcount, first_bc);
        end
        if (wait_cnt > 0) begin
          avm_wait = 1;
          wait_cnt--;
        end else begin
          in_req = 0;
          req_cnt++;
          beats_left = int'(avm_burstcount);
          cur_addr = avm_addr;
          chk("req_expected", req_q.size() != 0, 1);
          if (req_q.size() != 0) begin
            r = req_q.pop_front();
            chk("req_addr", avm_addr, r.addr);
            chk("req_len", avm_burstcount, r.len);
          end
        end
      end
      store_r = avm_rdvalid && !ctrl_abort;
      if (store_r) st_cnt++;
      pop_r = rd_req && model_lvl > 0 && !fifo_clr;
      emp_r = rd_req && model_lvl == 0 && !fifo_clr;
      clr_r = fifo_clr;
    end
  end

  initial forever begin
    @(posedge avm_clk); #1;
    rnd_req = pop_en && ($urandom_range(0, 99) < pop_pct);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge avm_clk); #1; end
  endtask

  task automatic start_block(input logic [AW-1:0] a, input int size);
    int words, rem;
    logic [AW-1:0] ad;
    words = size / B;
    for (int i = 0; i < words; i++) exp_q.push_back(dfun(a + AW'(i * B)));
    rem = words; ad = a;
    while (rem > 0) begin
      int l;
      l = (rem > MAXB) ? MAXB : rem;
      req_q.push_back('{ad, l});
      ad += AW'(l * B);
      rem -= l;
    end
    blk_addr = a; blk_size = LW'(size); st_cnt = 0;
    ctrl_start = 1;
  endtask

  task automatic wait_xfer(input string name, input int budget);
    int n = 0;
    while (!(req_q.size() == 0 && beats_left == 0 && !in_req) && n < budget) begin cyc(1); n++; end
    chk({name, "_complete"}, req_q.size() == 0 && beats_left == 0, 1);
    cyc(3);
  endtask

  task automatic finish_block(input string name);
    chk({name, "_busy_in_done"}, busy, 1);
    chk({name, "_no_early_end"}, blk_dma_end, 0);
    ctrl_start = 0;
    cyc(1);
    chk({name, "_end_pulse"}, blk_dma_end, 1);
    cyc(1);
    chk({name, "_end_one_cycle"}, blk_dma_end, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    pop_en = 1; pop_pct = 100;
    while (!(model_lvl == 0 && exp_q.size() == 0) && n < 200) begin cyc(1); n++; end
    pop_en = 0;
    chk({name, "_drained"}, model_lvl == 0 && exp_q.size() == 0, 1);
    cyc(2);
  endtask

  initial begin
    int n, e0, r0;
    logic [AW-1:0] ra;
    #2 avm_reset_n = 0;
    cyc(3);
    chk("rst_busy", busy, 0);          chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_addr", avm_addr, 0);  chk("rst_burstcount", avm_burstcount, 0);
    chk("rst_ovf", ovf, 0);            chk("rst_end", blk_dma_end, 0);
    chk("rst_rd_data", rd_data, 0);    chk("rst_level", fifo_level, 0);
    avm_reset_n = 1;
    cyc(2);

    // Short block, then flush and read-while-empty.
    stall_cfg = 0; gaps_en = 0;
    start_block(32'h1000, 6);
    wait_xfer("short", 100);
    chk("short_level", fifo_level, 3);
    finish_block("short");
    fifo_clr = 1; cyc(1); fifo_clr = 0; cyc(1);
    chk("clr_level", fifo_level, 0);
    man_req = 1; cyc(2); man_req = 0; cyc(1);

    // Multi-burst with 4-cycle stall on every request.
    stall_cfg = 4;
    start_block(32'h1000, 40);
    wait_xfer("multi", 400);
    chk("multi_level", fifo_level, 20);
    finish_block("multi");
    drain("multi");

    // Free-space flow control.
    stall_cfg = 0; gaps_en = 1;
    start_block(32'h2000, 128);
    n = 0;
    while (!(model_lvl == 32 && beats_left == 0) && n < 400) begin cyc(1); n++; end
    cyc(10);
    chk("flow_level_full", fifo_level, 32);
    chk("flow_read_held", avm_read, 0);
    chk("flow_pending_bursts", req_q.size(), 4);
    man_req = 1; cyc(8); man_req = 0;
    n = 0;
    while (req_q.size() != 3 && n < 50) begin cyc(1); n++; end
    chk("flow_resumed", req_q.size(), 3);
    chk("flow_ovf", ovf, 0);
    pop_en = 1; pop_pct = 50;
    wait_xfer("flow", 1000);
    finish_block("flow");
    drain("flow");

    // Abort after two beats of an eight-beat burst.
    gaps_en = 0;
    e0 = end_cnt;
    start_block(32'h3000, 16);
    n = 0;
    while (st_cnt < 2 && n < 100) begin cyc(1); n++; end
    ctrl_abort = 1;
    n = 0;
    while (busy && n < 50) begin cyc(1); n++; end
    chk("abort_idle", busy, 0);
    chk("abort_level", fifo_level, 2);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    ctrl_abort = 0; ctrl_start = 0;
    cyc(3);
    chk("abort_no_end", end_cnt, e0);
    chk("abort_stay_idle", busy, 0);
    drain("abort");

    // Zero-length block and byte-remainder truncation.
    r0 = req_cnt;
    start_block(32'h4000, 0);
    cyc(4);
    chk("zero_no_read", req_cnt, r0);
    finish_block("zero");
    start_block(32'h4100, 7);
    wait_xfer("odd", 100);
    chk("odd_level", fifo_level, 3);
    finish_block("odd");
    drain("odd");

    // Asynchronous reset while beats are in flight.
    start_block(32'h5000, 40);
    n = 0;
    while (!(beats_left > 0 && beats_left < 6) && n < 100) begin cyc(1); n++; end
    avm_reset_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);        chk("mid_rst_read", avm_read, 0);
    chk("mid_rst_addr", avm_addr, 0);    chk("mid_rst_bc", avm_burstcount, 0);
    chk("mid_rst_level", fifo_level, 0); chk("mid_rst_rd_data", rd_data, 0);
    ctrl_start = 0;
    cyc(2);
    avm_reset_n = 1;
    cyc(2);
    start_block(32'h6000, 20);
    wait_xfer("post_rst", 200);
    finish_block("post_rst");
    drain("post_rst");

    // Randomised blocks with concurrent reads, random stalls and beat gaps.
    stall_cfg = -1; gaps_en = 1;
    for (int k = 0; k < 12; k++) begin
      pop_en = 1; pop_pct = $urandom_range(20, 90);
      ra = $urandom;
      start_block(ra, $urandom_range(0, 90));
      wait_xfer("rand", 3000);
      finish_block("rand");
    end
    drain("rand");
    chk("final_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
